// File: rtl/map_sprite_writer.sv
// Tile map writer for N sprites: round-robin grant, then read-modify-write
// of the old cell (restore under tile) and the new cell (stamp sprite code).
module map_sprite_writer #(
    parameter int NUM_SPRITES = 3,
    parameter int COLS = 40,
    parameter int ROWS = 30,
    parameter int TILE_W = 4,
    parameter int RD_LAT = 2,
    parameter logic [TILE_W-1:0] EMPTY_CODE = '0,
    parameter logic [NUM_SPRITES-1:0] EATER_MASK = NUM_SPRITES'(1),
    parameter int XW = $clog2(COLS),
    parameter int YW = $clog2(ROWS),
    parameter int WW = COLS * TILE_W
) (
    input  logic                          CLOCK_50,
    input  logic                          reset_n,
    input  logic [NUM_SPRITES-1:0]        req,
    input  logic [NUM_SPRITES*XW-1:0]     curr_x,
    input  logic [NUM_SPRITES*YW-1:0]     curr_y,
    input  logic [NUM_SPRITES*XW-1:0]     next_x,
    input  logic [NUM_SPRITES*YW-1:0]     next_y,
    input  logic [NUM_SPRITES*TILE_W-1:0] sprite_code,
    output logic [NUM_SPRITES-1:0]        done,
    output logic                          err,
    output logic                          busy,
    output logic [YW-1:0]                 ram_addr,
    output logic [WW-1:0]                 ram_wrdata,
    output logic                          ram_wren,
    input  logic [WW-1:0]                 ram_rddata
);

    localparam int GW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int PW = $clog2(WW);
    localparam logic [CW-1:0] CNT_LAST = CW'(RD_LAT - 1);
    localparam logic [WW-1:0] TMASK = WW'({TILE_W{1'b1}});

    typedef enum logic [2:0] {
        IDLE, RD_CURR, WR_CURR, RD_NEXT, WR_NEXT, DONE
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [GW-1:0]       rr;
    logic [GW-1:0]       g;
    logic [XW-1:0]       cx, nx;
    logic [YW-1:0]       cy, ny;
    logic [TILE_W-1:0]   code_l;
    logic                same_l;
    logic [TILE_W-1:0]   under [NUM_SPRITES];

    logic                gnt_found;
    logic [GW-1:0]       gnt_idx;
    logic [GW-1:0]       cand;
    logic [XW-1:0]       g_cx, g_nx;
    logic [YW-1:0]       g_cy, g_ny;
    logic [TILE_W-1:0]   g_code;
    logic                g_bad, g_same;
    logic [PW-1:0]       csh, nsh, wsh;
    logic [TILE_W-1:0]   old_t, new_under, wtile;

    // Search starts just after the last winner so every requester gets a turn
    always_comb begin
        int i;
        gnt_found = 1'b0;
        gnt_idx = '0;
        cand = '0;
        for (int k = 1; k <= NUM_SPRITES; k++) begin
            i = int'(rr) + k;
            if (i >= NUM_SPRITES) i = i - NUM_SPRITES;
            cand = GW'(i);
            if (!gnt_found && req[cand]) begin
                gnt_found = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign g_cx = XW'(curr_x >> (XW * int'(gnt_idx)));
    assign g_cy = YW'(curr_y >> (YW * int'(gnt_idx)));
    assign g_nx = XW'(next_x >> (XW * int'(gnt_idx)));
    assign g_ny = YW'(next_y >> (YW * int'(gnt_idx)));
    assign g_code = TILE_W'(sprite_code >> (TILE_W * int'(gnt_idx)));
    assign g_bad = (int'(g_cx) >= COLS) || (int'(g_nx) >= COLS) ||
                   (int'(g_cy) >= ROWS) || (int'(g_ny) >= ROWS);
    assign g_same = (g_cx == g_nx) && (g_cy == g_ny);

    // Column 0 sits at the MSB end of the row word
    assign csh = PW'(TILE_W * (COLS - 1 - int'(cx)));
    assign nsh = PW'(TILE_W * (COLS - 1 - int'(nx)));
    assign old_t = TILE_W'(ram_rddata >> nsh);

    always_comb begin
        new_under = old_t;
        if (EATER_MASK[g]) new_under = EMPTY_CODE;
        for (int j = 0; j < NUM_SPRITES; j++) begin
            if (old_t == sprite_code[j*TILE_W +: TILE_W])
                new_under = EMPTY_CODE;
        end
    end

    always_comb begin
        wsh = nsh;
        wtile = code_l;
        if (state == WR_CURR) begin
            wsh = csh;
            wtile = under[g];
        end
        ram_wrdata = '0;
        if (state == WR_CURR || state == WR_NEXT)
            ram_wrdata = (ram_rddata & ~(TMASK << wsh)) |
                         (WW'(wtile) << wsh);
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt <= '0;
            rr <= GW'(NUM_SPRITES - 1);
            g <= '0;
            cx <= '0;
            cy <= '0;
            nx <= '0;
            ny <= '0;
            code_l <= '0;
            same_l <= 1'b0;
            done <= '0;
            err <= 1'b0;
            busy <= 1'b0;
            ram_wren <= 1'b0;
            ram_addr <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) under[i] <= EMPTY_CODE;
        end else begin
            done <= '0;
            err <= 1'b0;
            ram_wren <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (gnt_found) begin
                        g <= gnt_idx;
                        rr <= gnt_idx;
                        cx <= g_cx;
                        cy <= g_cy;
                        nx <= g_nx;
                        ny <= g_ny;
                        code_l <= g_code;
                        same_l <= g_same;
                        busy <= 1'b1;
                        cnt <= '0;
                        if (g_bad) begin
                            state <= DONE;
                            done <= NUM_SPRITES'(1) << gnt_idx;
                            err <= 1'b1;
                        end else if (g_same) begin
                            state <= RD_NEXT;
                            ram_addr <= g_ny;
                        end else begin
                            state <= RD_CURR;
                            ram_addr <= g_cy;
                        end
                    end
                end
                RD_CURR: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        state <= WR_CURR;
                        ram_wren <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WR_CURR: begin
                    state <= RD_NEXT;
                    ram_addr <= ny;
                end
                RD_NEXT: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        state <= WR_NEXT;
                        ram_wren <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WR_NEXT: begin
                    if (!same_l) under[g] <= new_under;
                    state <= DONE;
                    done <= NUM_SPRITES'(1) << g;
                end
                DONE: begin
                    state <= IDLE;
                    busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_map_sprite_writer.sv
// Bench for map_sprite_writer: RAM model plus a tile-level map/under model,
// directed scenarios followed by randomized moves.
module tb_map_sprite_writer;

    localparam int N = 3;
    localparam int COLS = 40;
    localparam int ROWS = 30;
    localparam int TW = 4;
    localparam int RD_LAT = 2;
    localparam int XW = 6;
    localparam int YW = 5;
    localparam int WW = COLS * TW;
    localparam logic [TW-1:0] EMPTY = 4'd0;
    localparam logic [N-1:0] EATER = 3'b001;

    logic CLOCK_50 = 1'b0;
    logic reset_n = 1'b0;
    logic [N-1:0] req;
    logic [N*XW-1:0] curr_x, next_x;
    logic [N*YW-1:0] curr_y, next_y;
    logic [N*TW-1:0] sprite_code;
    logic [N-1:0] done;
    logic err, busy, ram_wren;
    logic [YW-1:0] ram_addr;
    logic [WW-1:0] ram_wrdata, ram_rddata;

    logic [XW-1:0] cxa [N];
    logic [XW-1:0] nxa [N];
    logic [YW-1:0] cya [N];
    logic [YW-1:0] nya [N];
    logic [TW-1:0] codes [N] = '{4'd4, 4'd5, 4'd6};

    logic [TW-1:0] ref_map [ROWS][COLS];
    logic [TW-1:0] ref_under [N];
    int ref_rr;

    logic [WW-1:0] mem [ROWS];
    logic [WW-1:0] pipe [RD_LAT];
    logic load = 1'b0;
    int wren_cnt = 0;
    int checks = 0;
    int errors = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    map_sprite_writer #(
        .NUM_SPRITES(N), .COLS(COLS), .ROWS(ROWS), .TILE_W(TW),
        .RD_LAT(RD_LAT), .EMPTY_CODE(EMPTY), .EATER_MASK(EATER)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .req(req),
        .curr_x(curr_x), .curr_y(curr_y),
        .next_x(next_x), .next_y(next_y),
        .sprite_code(sprite_code), .done(done), .err(err),
        .busy(busy), .ram_addr(ram_addr), .ram_wrdata(ram_wrdata),
        .ram_wren(ram_wren), .ram_rddata(ram_rddata)
    );

    always_comb begin
        curr_x = '0;
        curr_y = '0;
        next_x = '0;
        next_y = '0;
        sprite_code = '0;
        for (int i = 0; i < N; i++) begin
            curr_x[i*XW +: XW] = cxa[i];
            curr_y[i*YW +: YW] = cya[i];
            next_x[i*XW +: XW] = nxa[i];
            next_y[i*YW +: YW] = nya[i];
            sprite_code[i*TW +: TW] = codes[i];
        end
    end

    function automatic logic [WW-1:0] ref_word(input int r);
        logic [WW-1:0] w;
        w = '0;
        for (int c = 0; c < COLS; c++)
            w = w | (WW'(ref_map[r][c]) << (TW * (COLS - 1 - c)));
        return w;
    endfunction

    function automatic logic [TW-1:0] mem_tile(input int r, input int c);
        return TW'(mem[r] >> (TW * (COLS - 1 - c)));
    endfunction

    // Port-b RAM with RD_LAT read pipeline; write lands at the clock edge
    always @(posedge CLOCK_50) begin
        if (load) begin
            for (int r = 0; r < ROWS; r++) mem[r] <= ref_word(r);
        end else if (ram_wren && int'(ram_addr) < ROWS) begin
            mem[ram_addr] <= ram_wrdata;
        end
        pipe[0] <= (int'(ram_addr) < ROWS) ? mem[ram_addr] : '0;
        for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
        if (ram_wren) wren_cnt <= wren_cnt + 1;
    end
    assign ram_rddata = pipe[RD_LAT-1];

    task automatic chk(input string tag, input logic [WW-1:0] obs,
                       input logic [WW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_map();
        @(negedge CLOCK_50);
        load = 1'b1;
        @(posedge CLOCK_50);
        #1 load = 1'b0;
    endtask

    task automatic model_move(input int s, input int cx, input int cy,
                              input int nx, input int ny,
                              output int lat, output int nw, output bit e);
        logic [TW-1:0] t;
        e = (cx >= COLS) || (nx >= COLS) || (cy >= ROWS) || (ny >= ROWS);
        if (e) begin
            lat = 1;
            nw = 0;
            return;
        end
        if (cx == nx && cy == ny) begin
            ref_map[ny][nx] = codes[s];
            lat = 2 + RD_LAT;
            nw = 1;
            return;
        end
        ref_map[cy][cx] = ref_under[s];
        t = ref_map[ny][nx];
        ref_map[ny][nx] = codes[s];
        if (EATER[s]) t = EMPTY;
        for (int j = 0; j < N; j++) if (t == codes[j]) t = EMPTY;
        ref_under[s] = t;
        lat = 3 + 2 * RD_LAT;
        nw = 2;
    endtask

    task automatic do_move(input int s, input int cx, input int cy,
                           input int nx, input int ny);
        int elat, enw, lat, w0;
        bit ee;
        logic [N-1:0] d_seen;
        logic e_seen, b_seen;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        cxa[s] = XW'(cx);
        cya[s] = YW'(cy);
        nxa[s] = XW'(nx);
        nya[s] = YW'(ny);
        model_move(s, cx, cy, nx, ny, elat, enw, ee);
        ref_rr = s;
        w0 = wren_cnt;
        req[s] = 1'b1;
        lat = 0;
        do begin
            @(posedge CLOCK_50);
            #1 lat++;
        end while (done == '0 && lat < 60);
        d_seen = done;
        e_seen = err;
        b_seen = busy;
        req[s] = 1'b0;
        chk($sformatf("latency s%0d", s), lat, elat);
        chk($sformatf("done s%0d", s), d_seen, N'(1) << s);
        chk($sformatf("err s%0d", s), e_seen, ee);
        chk($sformatf("busy at done s%0d", s), b_seen, 1'b1);
        chk($sformatf("writes s%0d", s), wren_cnt - w0, enw);
        if (cy < ROWS) chk($sformatf("row %0d", cy), mem[cy], ref_word(cy));
        if (ny < ROWS) chk($sformatf("row %0d", ny), mem[ny], ref_word(ny));
    endtask

    task automatic multi(input logic [N-1:0] mask);
        int exp_q[$];
        int got_q[$];
        logic [N-1:0] pend;
        int rr, cyc, elat, enw, s;
        bit ee;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        pend = mask;
        rr = ref_rr;
        while (pend != '0) begin
            for (int k = 1; k <= N; k++) begin
                s = (rr + k) % N;
                if (pend[s]) begin
                    exp_q.push_back(s);
                    pend[s] = 1'b0;
                    rr = s;
                    break;
                end
            end
        end
        foreach (exp_q[q])
            model_move(exp_q[q], int'(cxa[exp_q[q]]), int'(cya[exp_q[q]]),
                       int'(nxa[exp_q[q]]), int'(nya[exp_q[q]]),
                       elat, enw, ee);
        ref_rr = rr;
        req = mask;
        cyc = 0;
        while (got_q.size() < exp_q.size() && cyc < 200) begin
            @(posedge CLOCK_50);
            #1 cyc++;
            for (int i = 0; i < N; i++) begin
                if (done[i]) begin
                    got_q.push_back(i);
                    req[i] = 1'b0;
                end
            end
        end
        req = '0;
        chk("multi count", got_q.size(), exp_q.size());
        foreach (exp_q[q])
            chk($sformatf("order %0d", q),
                (q < got_q.size()) ? got_q[q] : -1, exp_q[q]);
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                chk("multi row c", mem[cya[i]], ref_word(int'(cya[i])));
                chk("multi row n", mem[nya[i]], ref_word(int'(nya[i])));
            end
        end
    endtask

    initial begin
        int s, cx, cy, nx, ny, r, w0;
        req = '0;
        for (int i = 0; i < N; i++) begin
            cxa[i] = '0;
            cya[i] = '0;
            nxa[i] = '0;
            nya[i] = '0;
            ref_under[i] = EMPTY;
        end
        ref_rr = N - 1;
        for (int rr = 0; rr < ROWS; rr++)
            for (int c = 0; c < COLS; c++)
                ref_map[rr][c] = TW'($urandom_range(0, 7));

        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("reset done", done, '0);
        chk("reset err", err, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset wren", ram_wren, 1'b0);
        chk("reset addr", ram_addr, '0);
        chk("reset wrdata", ram_wrdata, '0);
        @(negedge CLOCK_50);
        reset_n = 1'b1;

        // Pacman eats a pill
        for (int c = 0; c < COLS; c++) ref_map[20][c] = EMPTY;
        ref_map[20][20] = 4'd1;
        ref_map[5][11] = 4'd1;
        ref_map[5][12] = 4'd2;
        load_map();
        do_move(0, 19, 20, 20, 20);
        chk("pac col19", mem_tile(20, 19), 4'd0);
        chk("pac col20", mem_tile(20, 20), 4'd4);

        // Ghost crosses a pill and restores it
        do_move(1, 10, 5, 11, 5);
        do_move(1, 11, 5, 12, 5);
        chk("ghost col11", mem_tile(5, 11), 4'd1);
        chk("ghost col12", mem_tile(5, 12), 4'd5);

        // Stationary move keeps the under tile (2 from col 12)
        do_move(1, 8, 3, 8, 3);
        chk("same col8", mem_tile(3, 8), 4'd5);
        do_move(1, 8, 3, 9, 3);
        chk("same under", mem_tile(3, 8), 4'd2);

        do_move(2, 5, 3, 40, 3);

        // Round robin from pointer 2
        for (int i = 0; i < N; i++) begin
            cxa[i] = XW'(2 + i);
            cya[i] = YW'(22 + i);
            nxa[i] = XW'(3 + i);
            nya[i] = YW'(22 + i);
        end
        multi(3'b111);
        cxa[0] = 6'd3;
        nxa[0] = 6'd4;
        cxa[2] = 6'd5;
        nxa[2] = 6'd6;
        multi(3'b101);

        for (int t = 0; t < 40; t++) begin
            s = $urandom_range(0, N - 1);
            r = $urandom_range(0, 7);
            cx = $urandom_range(0, COLS - 1);
            cy = $urandom_range(0, ROWS - 1);
            nx = $urandom_range(0, COLS - 1);
            ny = $urandom_range(0, ROWS - 1);
            if (r == 0) nx = $urandom_range(COLS, 63);
            if (r == 1) cy = $urandom_range(ROWS, 31);
            if (r == 2) begin
                nx = cx;
                ny = cy;
            end
            do_move(s, cx, cy, nx, ny);
        end

        // Ghost picks up a pill, then reset lands mid-move of pacman
        ref_map[12][7] = 4'd1;
        ref_map[14][4] = 4'd3;
        load_map();
        do_move(1, 6, 12, 7, 12);
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        cxa[0] = 6'd3;
        cya[0] = 5'd14;
        nxa[0] = 6'd4;
        nya[0] = 5'd14;
        req[0] = 1'b1;
        w0 = wren_cnt;
        repeat (4) begin
            @(posedge CLOCK_50);
            #1;
        end
        ref_map[14][3] = ref_under[0];
        reset_n = 1'b0;
        #1;
        chk("midrst wren", ram_wren, 1'b0);
        chk("midrst busy", busy, 1'b0);
        chk("midrst done", done, '0);
        chk("midrst writes", wren_cnt - w0, 1);
        req = '0;
        for (int i = 0; i < N; i++) ref_under[i] = EMPTY;
        ref_rr = N - 1;
        repeat (2) @(negedge CLOCK_50);
        reset_n = 1'b1;
        chk("midrst row14", mem[14], ref_word(14));
        do_move(0, 3, 14, 4, 14);
        chk("post rst col3", mem_tile(14, 3), EMPTY);
        do_move(1, 7, 12, 8, 12);
        chk("post rst ghost", mem_tile(12, 7), EMPTY);

        for (int rr = 0; rr < ROWS; rr++)
            chk($sformatf("final row %0d", rr), mem[rr], ref_word(rr));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
